// File: rtl/rv32_pkg.sv
// Shared RV32IM core types: ALU operation encoding used between ID, EX and the ALU.
package rv32_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the EX ALU,
// store-data path and writeback control toward EX/MEM.
module id_ex_stage
  import rv32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  alu_op_e         id_alu_op,
  input  logic            id_a_sel_pc,
  input  logic            id_b_sel_imm,
  input  logic            id_reg_write,
  input  logic            mem_fwd_valid,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_valid,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output alu_op_e         alu_op,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_reg_write
);

  logic            valid_q,     valid_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [4:0]      rs1_addr_q,  rs1_addr_d;
  logic [4:0]      rs2_addr_q,  rs2_addr_d;
  logic [4:0]      rd_addr_q,   rd_addr_d;
  alu_op_e         alu_op_q,    alu_op_d;
  logic            a_sel_pc_q,  a_sel_pc_d;
  logic            b_sel_imm_q, b_sel_imm_d;
  logic            reg_write_q, reg_write_d;

  logic            load;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Handshake: a transfer ID->EX happens on a rising edge when id_valid & id_ready;
  // id_ready depends only on this stage's occupancy and ex_ready, never on id_valid.
  assign id_ready = !valid_q || ex_ready;
  assign load     = id_valid && id_ready && !flush;

  // x0 reads as zero and is never a forward target; MEM is younger so it beats WB.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    fwd_rs2 = rs2_data_q;
    if (rs1_addr_q == 5'd0) begin
      fwd_rs1 = '0;
    end else if (FWD_EN && mem_fwd_valid && (mem_fwd_rd == rs1_addr_q)) begin
      fwd_rs1 = mem_fwd_data;
    end else if (FWD_EN && wb_fwd_valid && (wb_fwd_rd == rs1_addr_q)) begin
      fwd_rs1 = wb_fwd_data;
    end
    if (rs2_addr_q == 5'd0) begin
      fwd_rs2 = '0;
    end else if (FWD_EN && mem_fwd_valid && (mem_fwd_rd == rs2_addr_q)) begin
      fwd_rs2 = mem_fwd_data;
    end else if (FWD_EN && wb_fwd_valid && (wb_fwd_rd == rs2_addr_q)) begin
      fwd_rs2 = wb_fwd_data;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    alu_op_d    = alu_op_q;
    a_sel_pc_d  = a_sel_pc_q;
    b_sel_imm_d = b_sel_imm_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d     = 1'b1;
      pc_d        = id_pc;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rd_addr_d   = id_rd_addr;
      alu_op_d    = id_alu_op;
      a_sel_pc_d  = id_a_sel_pc;
      b_sel_imm_d = id_b_sel_imm;
      reg_write_d = id_reg_write;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Latch forwarded operands so they outlive a producer that retires mid-stall.
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      alu_op_q    <= ALU_ADD;
      a_sel_pc_q  <= 1'b0;
      b_sel_imm_q <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      alu_op_q    <= alu_op_d;
      a_sel_pc_q  <= a_sel_pc_d;
      b_sel_imm_q <= b_sel_imm_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign alu_op        = alu_op_q;
  assign alu_a         = a_sel_pc_q  ? pc_q  : fwd_rs1;
  assign alu_b         = b_sel_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = reg_write_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: handshake, forwarding priority, stall capture,
// flush and asynchronous reset, each with hand-computed expected values.
module tb_id_ex_stage;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  alu_op_e     id_alu_op;
  logic        id_a_sel_pc, id_b_sel_imm, id_reg_write;
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  alu_op_e     alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_alu_op(id_alu_op),
    .id_a_sel_pc(id_a_sel_pc), .id_b_sel_imm(id_b_sel_imm), .id_reg_write(id_reg_write),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [31:0] pc,
                          input logic [4:0] rs1a, input logic [31:0] rs1d,
                          input logic [4:0] rs2a, input logic [31:0] rs2d,
                          input logic [31:0] imm, input logic [4:0] rd,
                          input alu_op_e op, input logic asel, input logic bsel,
                          input logic rw);
    id_pc        = pc;
    id_rs1_addr  = rs1a;
    id_rs1_data  = rs1d;
    id_rs2_addr  = rs2a;
    id_rs2_data  = rs2d;
    id_imm       = imm;
    id_rd_addr   = rd;
    id_alu_op    = op;
    id_a_sel_pc  = asel;
    id_b_sel_imm = bsel;
    id_reg_write = rw;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    drive_id(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b0);
    mem_fwd_valid = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h0;
    wb_fwd_valid  = 1'b0; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'h0;
    repeat (2) tick();

    // reset state
    check("rst_valid", {31'b0, ex_valid}, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_store", ex_store_data, 32'h0);
    check("rst_op", 32'(alu_op), 32'(ALU_ADD));
    check("rst_rw", {31'b0, ex_reg_write}, 32'h0);
    check("rst_ready", {31'b0, id_ready}, 32'h1);
    rst = 1'b0;
    tick();

    // pass-through ADD x3 = x1(5) + x2(7)
    drive_id(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 5'd3, ALU_ADD, 1'b0, 1'b0, 1'b1);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("pt_valid", {31'b0, ex_valid}, 32'h1);
    check("pt_alu_a", alu_a, 32'd5);
    check("pt_alu_b", alu_b, 32'd7);
    check("pt_pc", ex_pc, 32'h100);
    check("pt_rd", {27'b0, ex_rd_addr}, 32'd3);
    check("pt_rw", {31'b0, ex_reg_write}, 32'h1);
    tick();
    check("bubble_valid", {31'b0, ex_valid}, 32'h0);
    check("bubble_rw", {31'b0, ex_reg_write}, 32'h0);

    // forwarding priority on rs1 = x3, b = imm, store data = rs2 (x5)
    drive_id(32'h104, 5'd3, 32'h99, 5'd5, 32'h55, 32'h40, 5'd6, ALU_SUB, 1'b0, 1'b1, 1'b1);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h11;
    wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd3; wb_fwd_data  = 32'h22;
    #1;
    check("prio_mem", alu_a, 32'h11);
    check("prio_imm", alu_b, 32'h40);
    check("prio_store", ex_store_data, 32'h55);
    check("prio_op", 32'(alu_op), 32'(ALU_SUB));
    mem_fwd_valid = 1'b0;
    #1;
    check("prio_wb", alu_a, 32'h22);
    wb_fwd_valid = 1'b0;
    #1;
    check("prio_rf", alu_a, 32'h99);
    tick();

    // x0 is never forwarded
    drive_id(32'h108, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd7, ALU_ADD, 1'b0, 1'b0, 1'b1);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h11;
    wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'h22;
    #1;
    check("x0_alu_a", alu_a, 32'h0);
    check("x0_alu_b", alu_b, 32'h0);
    mem_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;
    tick();

    // a = PC, b = imm
    drive_id(32'h200, 5'd1, 32'h5, 5'd2, 32'h6, 32'h4, 5'd1, ALU_ADD, 1'b1, 1'b1, 1'b1);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("pcsel_a", alu_a, 32'h200);
    check("pcsel_b", alu_b, 32'h4);
    tick();

    // stall capture of WB forward on rs2 = x4, with back-pressure on a new ID instruction
    drive_id(32'h300, 5'd1, 32'h10, 5'd4, 32'h1111, 32'h8, 5'd9, ALU_OR, 1'b0, 1'b0, 1'b1);
    id_valid = 1'b1;
    tick();
    ex_ready = 1'b0;
    drive_id(32'h400, 5'd2, 32'h20, 5'd3, 32'h30, 32'hC, 5'd10, ALU_AND, 1'b0, 1'b0, 1'b1);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'hABCD;
    #1;
    check("bp_ready", {31'b0, id_ready}, 32'h0);
    check("stall_fwd_b", alu_b, 32'hABCD);
    tick();
    wb_fwd_valid = 1'b0;
    #1;
    check("stall_hold_b", alu_b, 32'hABCD);
    check("stall_hold_st", ex_store_data, 32'hABCD);
    check("stall_hold_a", alu_a, 32'h10);
    check("stall_valid", {31'b0, ex_valid}, 32'h1);
    tick();
    check("bp_pc", ex_pc, 32'h300);
    check("bp_op", 32'(alu_op), 32'(ALU_OR));
    id_valid = 1'b0;
    ex_ready = 1'b1;
    #1;
    check("release_ready", {31'b0, id_ready}, 32'h1);
    check("release_b", alu_b, 32'hABCD);
    tick();
    check("release_bubble", {31'b0, ex_valid}, 32'h0);

    // flush beats a simultaneous load
    drive_id(32'h500, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd10, ALU_ADD, 1'b0, 1'b0, 1'b1);
    id_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; id_valid = 1'b0;
    check("flush_load_valid", {31'b0, ex_valid}, 32'h0);
    check("flush_load_rw", {31'b0, ex_reg_write}, 32'h0);

    // flush kills a stalled instruction
    drive_id(32'h504, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd11, ALU_ADD, 1'b0, 1'b0, 1'b1);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("flush_pre_valid", {31'b0, ex_valid}, 32'h1);
    ex_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_held_valid", {31'b0, ex_valid}, 32'h0);
    check("flush_held_ready", {31'b0, id_ready}, 32'h1);
    ex_ready = 1'b1;

    // asynchronous reset mid-stream
    drive_id(32'h600, 5'd1, 32'h77, 5'd2, 32'h88, 32'h0, 5'd12, ALU_XOR, 1'b0, 1'b0, 1'b1);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0; ex_ready = 1'b0;
    check("pre_rst_a", alu_a, 32'h77);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, ex_valid}, 32'h0);
    check("arst_alu_a", alu_a, 32'h0);
    check("arst_op", 32'(alu_op), 32'(ALU_ADD));
    check("arst_ready", {31'b0, id_ready}, 32'h1);
    tick();
    rst = 1'b0;
    tick();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
